// File: rtl/vseq_pkg.sv
// vseq_pkg: shared FSM encoding, vector word layout and error saturation for vector_sequencer
package vseq_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        SETTLE   = 3'd3,
        WAIT_ADC = 3'd4,
        CHECK    = 3'd5,
        DONE     = 3'd6
    } state_t;
    localparam int EXP_LSB = 0;
    localparam logic [15:0] ERR_SAT = 16'hFFFF;
    // The stimulus half sits directly above the expected half.
    function automatic int stim_lsb(input int data_w);
        return EXP_LSB + data_w;
    endfunction
endpackage

// File: rtl/vector_sequencer_if.sv
// vector_sequencer_if: vector RAM, DIO stimulus and ADC sample signals of the sequencer
interface vector_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   vec_rd_addr;
    logic [2*DATA_W-1:0] vec_rd_data;
    logic [DATA_W-1:0]   dio_drive;
    logic                dio_valid;
    logic                adc_ready;
    logic [DATA_W-1:0]   adc_data;
    modport master (
        output vec_rd_addr, dio_drive, dio_valid,
        input  vec_rd_data, adc_ready, adc_data
    );
    modport slave (
        input  vec_rd_addr, dio_drive, dio_valid,
        output vec_rd_data, adc_ready, adc_data
    );
endinterface

// File: rtl/vseq_tol_compare.sv
// vseq_tol_compare: registered flag that |a - b| exceeds TOL, loaded when en is high
module vseq_tol_compare #(
    parameter int DATA_W = 16,
    parameter int TOL    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              over
);
    logic [DATA_W:0] diff;
    assign diff = a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
    always_ff @(posedge clk) begin
        if (!rst_n) over <= 1'b0;
        else if (en) over <= diff > (DATA_W + 1)'(TOL);
    end
endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: steps the vector RAM through stimulus, settle, ADC wait and tolerance check.
// Optional VSEQ_STOP_ON_FAIL_EN ends the run at the first error and adds fail_addr.
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int SETTLE_CYC = 4,
    parameter int TOL        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [15:0]       timeout_cyc,
    vector_sequencer_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] cur_addr
`ifdef VSEQ_STOP_ON_FAIL_EN
    ,
    output logic [ADDR_W-1:0] fail_addr
`endif
);
    localparam int STIM_LSB = stim_lsb(DATA_W);
    state_t state, nxt;
    logic [ADDR_W-1:0] last_q, next_addr;
    logic [15:0] tmo_cyc_q, cnt;
    logic [DATA_W-1:0] exp_q;
    logic tmo_q, over, tmo_hit, settled, err_inc, stop, go;
    assign go        = state == IDLE && start && !abort;
    assign next_addr = cur_addr + 1'b1;
    assign settled   = cnt == 16'(SETTLE_CYC - 1);
    assign tmo_hit   = !bus.adc_ready && tmo_cyc_q != 16'd0 && cnt == tmo_cyc_q - 16'd1;
    // A timed-out vector leaves a stale compare result, so tmo_q masks it in CHECK.
    assign err_inc   = !abort && ((state == WAIT_ADC && tmo_hit) || (state == CHECK && over && !tmo_q));
`ifdef VSEQ_STOP_ON_FAIL_EN
    assign stop = tmo_q || over;
`else
    assign stop = 1'b0;
`endif
    vseq_tol_compare #(.DATA_W(DATA_W), .TOL(TOL)) u_cmp (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == WAIT_ADC && bus.adc_ready),
        .a    (bus.adc_data),
        .b    (exp_q),
        .over (over)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = start ? FETCH : IDLE;
            FETCH:    nxt = LOAD;
            LOAD:     nxt = SETTLE;
            SETTLE:   nxt = settled ? WAIT_ADC : SETTLE;
            WAIT_ADC: nxt = bus.adc_ready || tmo_hit ? CHECK : WAIT_ADC;
            CHECK:    nxt = cur_addr == last_q || stop ? DONE : FETCH;
            default:  nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_comb begin
        busy = state != IDLE && state != DONE;
        done = state == DONE && !abort;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q          <= '0;
            tmo_cyc_q       <= '0;
            cnt             <= '0;
            exp_q           <= '0;
            tmo_q           <= 1'b0;
            cur_addr        <= '0;
            err_count       <= '0;
            timeout_err     <= 1'b0;
            pass            <= 1'b0;
            bus.vec_rd_addr <= '0;
            bus.dio_drive   <= '0;
            bus.dio_valid   <= 1'b0;
`ifdef VSEQ_STOP_ON_FAIL_EN
            fail_addr       <= '0;
`endif
        end else if (go) begin
            last_q          <= last_addr;
            tmo_cyc_q       <= timeout_cyc;
            cur_addr        <= first_addr;
            bus.vec_rd_addr <= first_addr;
            err_count       <= '0;
            timeout_err     <= 1'b0;
            pass            <= 1'b0;
            bus.dio_valid   <= 1'b0;
`ifdef VSEQ_STOP_ON_FAIL_EN
            fail_addr       <= '0;
`endif
        end else if (state != IDLE && abort) begin
            pass          <= 1'b0;
            bus.dio_valid <= 1'b0;
        end else begin
            cnt <= (state == SETTLE && !settled) || state == WAIT_ADC ? cnt + 16'd1 : 16'd0;
            if (err_inc) err_count <= err_count == ERR_SAT ? err_count : err_count + 16'd1;
            if (state == WAIT_ADC) tmo_q <= tmo_hit;
            if (state == WAIT_ADC && tmo_hit) timeout_err <= 1'b1;
            if (state == LOAD) begin
                bus.dio_drive <= bus.vec_rd_data[STIM_LSB +: DATA_W];
                exp_q         <= bus.vec_rd_data[EXP_LSB +: DATA_W];
                bus.dio_valid <= 1'b1;
            end
            if (state == CHECK && nxt == FETCH) begin
                cur_addr        <= next_addr;
                bus.vec_rd_addr <= next_addr;
            end
`ifdef VSEQ_STOP_ON_FAIL_EN
            if (state == CHECK && stop) fail_addr <= cur_addr;
`endif
            if (state == DONE) pass <= err_count == 16'd0;
        end
    end
endmodule
